mem_watch_unit: RTL and testbench
=================================

// Module: mem_watch_unit
//
// PURPOSE
//   Parametrised run-control and data-memory watch block for processor simulation and bring-up.
//   - Snoops the data-memory write port.
//   - Tracks the latest value, hit count and change pulse for CHANNELS watched addresses.
//   - Counts run cycles and stops on processor halt or on a cycle watchdog limit.
//   - Sits beside the processor datamem; replaces hard-coded per-address monitors and fixed run lengths.
//
// PARAMETERS
//   ADDR_W   10   data-memory address width
//   DATA_W   32   data-memory word width
//   CHANNELS 2    number of watched addresses (>=1)
//   CNT_W    16   width of cycle counter and per-channel hit counters
//   TIMEOUT  100  watchdog limit in RUN cycles; 0 disables the watchdog
//
// PORTS
//   clk         in   1                 system clock, rising edge
//   rst_n       in   1                 async active-low reset
//   start       in   1                 IDLE->RUN request, level-sampled
//   clr         in   1                 sync clear to IDLE from any state
//   halt        in   1                 processor halt indication
//   watch_addr  in   CHANNELS*ADDR_W   watched address, channel i at [i*ADDR_W +: ADDR_W]
//   wr_en       in   1                 snooped datamem write enable
//   wr_addr     in   ADDR_W            snooped write address
//   wr_data     in   DATA_W            snooped write data
//   ch_value    out  CHANNELS*DATA_W   last value written to each watched address
//   ch_hits     out  CHANNELS*CNT_W    matching-write count per channel, saturating
//   ch_changed  out  CHANNELS          1-cycle pulse: channel value changed
//   cycle_count out  CNT_W             RUN cycles elapsed
//   state       out  2                 0=IDLE 1=RUN 2=DONE 3=TIMEOUT
//   done        out  1                 high in DONE or TIMEOUT
//   timed_out   out  1                 high in TIMEOUT only
//
// BEHAVIOUR
//   Reset (rst_n low, async):
//     state=IDLE; ch_value, ch_hits, ch_changed, cycle_count, done, timed_out all 0.
//   FSM transitions (registered):
//     IDLE -> RUN when start=1.
//     RUN -> DONE when halt=1.
//     RUN -> TIMEOUT when TIMEOUT!=0, cycle_count==TIMEOUT-1 and halt=0.
//     halt wins over timeout in the same cycle.
//     DONE/TIMEOUT hold until clr; start is ignored there.
//     clr=1 in any state: next cycle equals the reset state; clr beats start, halt and writes.
//   cycle_count:
//     +1 every cycle state==RUN, including the exit cycle.
//     Frozen in DONE/TIMEOUT; saturates at all-ones when TIMEOUT=0.
//   Snooping (state==RUN only; includes the halt cycle):
//     - If wr_en and wr_addr==watch_addr[i]: ch_value[i]<=wr_data next edge.
//     - ch_hits[i] +1, saturating at 2^CNT_W-1.
//     - ch_changed[i]=1 for exactly the following cycle iff wr_data != previous ch_value[i].
//   Other snooping rules:
//     - Several channels with the same address all update together.
//     - Writes in IDLE/DONE/TIMEOUT are ignored; ch_changed=0 outside the cycle after a RUN write.
//     - Latency: input edge -> outputs 1 cycle; no combinational input->output paths.
//     - watch_addr must be stable during RUN; a change takes effect on the next compare.
//     - A write of equal data counts a hit with no change pulse.
//
// CONFIGURATION
//   MEMWATCH_TRACE_EN defined:
//     - On each ch_changed pulse, print "t=<time> ch=<i> addr=<a> old=<o> new=<n>".
//     - On entering DONE/TIMEOUT, print one summary line (state, cycle_count, every ch_value).
//     - The print logic is simulation-only.
//   MEMWATCH_TRACE_EN undefined:
//     - No system tasks; block is fully synthesizable.
//     - Port behaviour is identical in both builds.
//
// TESTING
//   1. Reset, start=1 one cycle, write addr2=7 then addr3=9 (watch={3,2})
//      -> ch_value={9,7}, hits={1,1}, one ch_changed pulse each.
//   2. Write addr2=7 twice more -> hits[0]=3, no further ch_changed[0] pulse.
//   3. halt=1 on cycle 40 of RUN, same-cycle write addr3=5
//      -> state=DONE, done=1, timed_out=0, cycle_count=40, ch_value[1]=5.
//   4. No halt, TIMEOUT=100 -> TIMEOUT entered after cycle_count 99, reads 100; done=1, timed_out=1.
//   5. halt and timeout coincide -> DONE. clr mid-RUN -> IDLE, all outputs 0 next cycle.
//   6. rst_n low mid-RUN with a write pending -> immediate reset values; write not captured.

Source files
------------

// File: rtl/mem_watch_unit.sv
// Run-control FSM plus data-memory write snooper for CHANNELS watched addresses.
// Optional simulation trace is enabled with `define MEMWATCH_TRACE_EN.
module mem_watch_unit #(
    parameter int ADDR_W   = 10,
    parameter int DATA_W   = 32,
    parameter int CHANNELS = 2,
    parameter int CNT_W    = 16,
    parameter int TIMEOUT  = 100
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         start,
    input  logic                         clr,
    input  logic                         halt,
    input  logic [CHANNELS*ADDR_W-1:0]   watch_addr,
    input  logic                         wr_en,
    input  logic [ADDR_W-1:0]            wr_addr,
    input  logic [DATA_W-1:0]            wr_data,
    output logic [CHANNELS*DATA_W-1:0]   ch_value,
    output logic [CHANNELS*CNT_W-1:0]    ch_hits,
    output logic [CHANNELS-1:0]          ch_changed,
    output logic [CNT_W-1:0]             cycle_count,
    output logic [1:0]                   state,
    output logic                         done,
    output logic                         timed_out
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_RUN     = 2'd1,
        S_DONE    = 2'd2,
        S_TIMEOUT = 2'd3
    } state_t;

    localparam int TO_LAST_I = (TIMEOUT == 0) ? 0 : TIMEOUT - 1;
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TO_LAST_I);
    localparam logic             WDOG_EN = (TIMEOUT != 0);

    state_t           state_q;
    state_t           state_d;
    logic [CNT_W-1:0] cycle_q;

    // start and clr are plain level controls; clr overrides every other input.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:    if (start) state_d = S_RUN;
            S_RUN: begin
                if (halt)
                    state_d = S_DONE;
                else if (WDOG_EN && cycle_q == TO_LAST)
                    state_d = S_TIMEOUT;
            end
            S_DONE:    state_d = S_DONE;
            S_TIMEOUT: state_d = S_TIMEOUT;
            default:   state_d = S_IDLE;
        endcase
        if (clr) state_d = S_IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state_q <= S_IDLE;
        else
            state_q <= state_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cycle_q <= '0;
        else if (clr)
            cycle_q <= '0;
        else if (state_q == S_RUN && cycle_q != {CNT_W{1'b1}})
            cycle_q <= cycle_q + CNT_W'(1);
    end

    assign cycle_count = cycle_q;
    assign state       = state_q;
    assign done        = (state_q == S_DONE) || (state_q == S_TIMEOUT);
    assign timed_out   = (state_q == S_TIMEOUT);

    for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
        logic [DATA_W-1:0] val_q;
        logic [CNT_W-1:0]  hit_q;
        logic              chg_q;
        logic              match;

        assign match = (state_q == S_RUN) && wr_en &&
                       (wr_addr == watch_addr[g*ADDR_W +: ADDR_W]);

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                val_q <= '0;
                hit_q <= '0;
                chg_q <= 1'b0;
            end else if (clr) begin
                val_q <= '0;
                hit_q <= '0;
                chg_q <= 1'b0;
            end else begin
                chg_q <= 1'b0;
                if (match) begin
                    val_q <= wr_data;
                    chg_q <= (wr_data != val_q);
                    if (hit_q != {CNT_W{1'b1}})
                        hit_q <= hit_q + CNT_W'(1);
                end
            end
        end

        assign ch_value[g*DATA_W +: DATA_W] = val_q;
        assign ch_hits[g*CNT_W +: CNT_W]    = hit_q;
        assign ch_changed[g]                = chg_q;

`ifdef MEMWATCH_TRACE_EN
        logic [DATA_W-1:0] old_q;
        always @(posedge clk) begin
            if (rst_n && !clr && match)
                old_q <= val_q;
            if (rst_n && chg_q)
                $display("t=%0t ch=%0d addr=%0d old=%0h new=%0h", $time, g,
                         watch_addr[g*ADDR_W +: ADDR_W], old_q, val_q);
        end
`endif
    end

`ifdef MEMWATCH_TRACE_EN
    // Flag the first cycle spent in DONE/TIMEOUT so the summary shows final values.
    logic entered_q;
    always @(posedge clk) begin
        entered_q <= rst_n && !clr && (state_q == S_RUN) &&
                     (state_d == S_DONE || state_d == S_TIMEOUT);
        if (rst_n && entered_q) begin
            $write("t=%0t memwatch state=%0d cycle_count=%0d", $time, state_q, cycle_q);
            for (int i = 0; i < CHANNELS; i++)
                $write(" ch%0d=%0h", i, ch_value[i*DATA_W +: DATA_W]);
            $display("");
        end
    end
`endif

endmodule

// File: tb/tb_mem_watch_unit.sv
// Directed bench for mem_watch_unit: vector table for snooping, hand sequences for
// halt, watchdog, clear and asynchronous reset corner cases.
module tb_mem_watch_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start, clr, halt, wr_en;
    logic [19:0] watch_addr;
    logic [9:0]  wr_addr;
    logic [31:0] wr_data;
    logic [63:0] ch_value;
    logic [31:0] ch_hits;
    logic [1:0]  ch_changed;
    logic [15:0] cycle_count;
    logic [1:0]  state;
    logic        done, timed_out;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_watch_unit dut (
        .clk(clk), .rst_n(rst_n), .start(start), .clr(clr), .halt(halt),
        .watch_addr(watch_addr), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .ch_value(ch_value), .ch_hits(ch_hits), .ch_changed(ch_changed),
        .cycle_count(cycle_count), .state(state), .done(done), .timed_out(timed_out)
    );

    typedef struct {
        logic        start, clr, halt, wr_en;
        logic [9:0]  addr;
        logic [31:0] data;
        logic [1:0]  st;
        logic [31:0] v0, v1;
        logic [15:0] h0, h1;
        logic [1:0]  chg;
        logic [15:0] cc;
    } vec_t;

    vec_t vecs[11];

    function automatic vec_t mk(logic s, logic c, logic h, logic we, logic [9:0] a,
                                logic [31:0] d, logic [1:0] st, logic [31:0] v0,
                                logic [31:0] v1, logic [15:0] h0, logic [15:0] h1,
                                logic [1:0] chg, logic [15:0] cc);
        vec_t v;
        v.start = s; v.clr = c; v.halt = h; v.wr_en = we; v.addr = a; v.data = d;
        v.st = st; v.v0 = v0; v.v1 = v1; v.h0 = h0; v.h1 = h1; v.chg = chg; v.cc = cc;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [1:0] st, input logic [31:0] v0,
                             input logic [31:0] v1, input logic [15:0] h0,
                             input logic [15:0] h1, input logic [1:0] chg,
                             input logic [15:0] cc);
        chk({tag, ".state"}, 64'(state), 64'(st));
        chk({tag, ".done"}, 64'(done), 64'(st == 2'd2 || st == 2'd3));
        chk({tag, ".timed_out"}, 64'(timed_out), 64'(st == 2'd3));
        chk({tag, ".value0"}, 64'(ch_value[31:0]), 64'(v0));
        chk({tag, ".value1"}, 64'(ch_value[63:32]), 64'(v1));
        chk({tag, ".hits0"}, 64'(ch_hits[15:0]), 64'(h0));
        chk({tag, ".hits1"}, 64'(ch_hits[31:16]), 64'(h1));
        chk({tag, ".changed"}, 64'(ch_changed), 64'(chg));
        chk({tag, ".cycle_count"}, 64'(cycle_count), 64'(cc));
    endtask

    // Drive on the falling edge, sample 1 time unit after the following rising edge.
    task automatic step(input logic s, input logic c, input logic h, input logic we,
                        input logic [9:0] a, input logic [31:0] d);
        @(negedge clk);
        start = s; clr = c; halt = h; wr_en = we; wr_addr = a; wr_data = d;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 1'b0, 1'b0, 10'd0, 32'd0);
    endtask

    logic [15:0] exp_cc;

    initial begin
        rst_n = 1'b0; start = 1'b0; clr = 1'b0; halt = 1'b0; wr_en = 1'b0;
        wr_addr = '0; wr_data = '0;
        watch_addr = {10'd3, 10'd2};   // channel 0 watches 2, channel 1 watches 3

        vecs[0]  = mk(0,0,0,0,10'd0,32'd0,  2'd0, 0,0, 0,0, 2'b00, 0);
        vecs[1]  = mk(1,0,0,0,10'd0,32'd0,  2'd1, 0,0, 0,0, 2'b00, 0);
        vecs[2]  = mk(0,0,0,1,10'd2,32'd7,  2'd1, 7,0, 1,0, 2'b01, 1);
        vecs[3]  = mk(0,0,0,1,10'd3,32'd9,  2'd1, 7,9, 1,1, 2'b10, 2);
        vecs[4]  = mk(0,0,0,0,10'd0,32'd0,  2'd1, 7,9, 1,1, 2'b00, 3);
        vecs[5]  = mk(0,0,0,1,10'd2,32'd7,  2'd1, 7,9, 2,1, 2'b00, 4);
        vecs[6]  = mk(0,0,0,1,10'd2,32'd7,  2'd1, 7,9, 3,1, 2'b00, 5);
        vecs[7]  = mk(0,0,0,1,10'd5,32'd1,  2'd1, 7,9, 3,1, 2'b00, 6);
        vecs[8]  = mk(0,0,0,0,10'd2,32'd8,  2'd1, 7,9, 3,1, 2'b00, 7);
        vecs[9]  = mk(0,0,0,1,10'd2,32'd4,  2'd1, 4,9, 4,1, 2'b01, 8);
        vecs[10] = mk(1,0,0,0,10'd0,32'd0,  2'd1, 4,9, 4,1, 2'b00, 9);

        repeat (2) @(posedge clk);
        #1;
        check_all("reset", 2'd0, 0, 0, 0, 0, 2'b00, 0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 11; i++) begin
            step(vecs[i].start, vecs[i].clr, vecs[i].halt, vecs[i].wr_en,
                 vecs[i].addr, vecs[i].data);
            check_all($sformatf("vec%0d", i), vecs[i].st, vecs[i].v0, vecs[i].v1,
                      vecs[i].h0, vecs[i].h1, vecs[i].chg, vecs[i].cc);
        end

        // Halt on the 40th RUN cycle together with a write to address 3.
        exp_cc = 16'd9;
        while (exp_cc < 16'd39) begin
            idle();
            exp_cc++;
        end
        chk("pre_halt.cycle_count", 64'(cycle_count), 64'd39);
        step(1'b0, 1'b0, 1'b1, 1'b1, 10'd3, 32'd5);
        check_all("halt", 2'd2, 4, 5, 4, 2, 2'b10, 40);
        step(1'b1, 1'b0, 1'b0, 1'b1, 10'd2, 32'd1);
        check_all("done_hold", 2'd2, 4, 5, 4, 2, 2'b00, 40);
        step(1'b0, 1'b1, 1'b0, 1'b0, 10'd0, 32'd0);
        check_all("clr_done", 2'd0, 0, 0, 0, 0, 2'b00, 0);

        // Watchdog: TIMEOUT entered when cycle_count reaches 100.
        step(1'b1, 1'b0, 1'b0, 1'b0, 10'd0, 32'd0);
        for (int k = 1; k <= 100; k++) begin
            idle();
            chk($sformatf("wdog%0d.cycle_count", k), 64'(cycle_count), 64'(k));
            chk($sformatf("wdog%0d.state", k), 64'(state), (k == 100) ? 64'd3 : 64'd1);
        end
        idle();
        check_all("timeout_hold", 2'd3, 0, 0, 0, 0, 2'b00, 100);
        step(1'b0, 1'b1, 1'b0, 1'b0, 10'd0, 32'd0);
        check_all("clr_timeout", 2'd0, 0, 0, 0, 0, 2'b00, 0);

        // Halt in the same cycle the watchdog would fire: DONE wins.
        step(1'b1, 1'b0, 1'b0, 1'b0, 10'd0, 32'd0);
        repeat (99) idle();
        chk("coincide_pre.cycle_count", 64'(cycle_count), 64'd99);
        step(1'b0, 1'b0, 1'b1, 1'b0, 10'd0, 32'd0);
        check_all("coincide", 2'd2, 0, 0, 0, 0, 2'b00, 100);
        step(1'b0, 1'b1, 1'b0, 1'b0, 10'd0, 32'd0);

        // clr mid-RUN beats a simultaneous write, halt and start.
        step(1'b1, 1'b0, 1'b0, 1'b0, 10'd0, 32'd0);
        step(1'b0, 1'b0, 1'b0, 1'b1, 10'd2, 32'd3);
        check_all("pre_clr", 2'd1, 3, 0, 1, 0, 2'b01, 1);
        step(1'b1, 1'b1, 1'b1, 1'b1, 10'd3, 32'd6);
        check_all("clr_run", 2'd0, 0, 0, 0, 0, 2'b00, 0);

        // Async reset mid-RUN with a write pending.
        step(1'b1, 1'b0, 1'b0, 1'b0, 10'd0, 32'd0);
        step(1'b0, 1'b0, 1'b0, 1'b1, 10'd3, 32'd11);
        check_all("pre_rst", 2'd1, 0, 11, 0, 1, 2'b10, 1);
        @(negedge clk);
        wr_en = 1'b1; wr_addr = 10'd2; wr_data = 32'd6;
        #2 rst_n = 1'b0;
        #1;
        check_all("async_rst", 2'd0, 0, 0, 0, 0, 2'b00, 0);
        @(posedge clk);
        #1;
        check_all("rst_hold", 2'd0, 0, 0, 0, 0, 2'b00, 0);
        @(negedge clk);
        rst_n = 1'b1; wr_en = 1'b0;
        idle();
        check_all("post_rst", 2'd0, 0, 0, 0, 0, 2'b00, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got running expected finished");
        $fatal(1);
    end

endmodule
